adder_tree_pipe_acc: RTL and testbench
======================================

Name: adder_tree_pipe_acc

Overview:
- Parametrised, fully pipelined N-input adder tree; successor to the fixed per-level tree stages.
- Each level reduces pairs and is registered; a final accumulate stage optionally sums a run of tree results.
- Adds valid/ready flow control with backpressure, signed/unsigned operation and a group flush.
- Sits after the multiplier array; feeds the activation/requant stage.

Parameters:
- N_IN, 16, number of input operands; power of 2, at least 2.
- IN_W, 16, width of each operand.
- SIGNED, 1, 1 = operands two's complement (sign-extend); 0 = unsigned (zero-extend).
- ACC_GROW, 8, extra accumulator guard bits.
- Derived: LEVELS = log2(N_IN); TREE_W = IN_W+LEVELS; OUT_W = TREE_W+ACC_GROW.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  N_IN*IN_W  packed operands; operand i at [i*IN_W +: IN_W]
- in_last  in  1  beat closes the current accumulation group early
- acc_len  in  8  beats per group; 0 or 1 = pass-through
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  group sum
- out_cnt  out  8  number of beats summed into out_data

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high. All stage registers, valid bits, accumulator and beat counter clear to 0. out_valid=0, out_data=0, out_cnt=0, in_ready=1 after reset.
- Stall: stall = out_valid & ~out_ready; in_ready = ~stall.
  - During stall every pipeline register, accumulator and counter holds.
  - out_data and out_cnt stay stable while out_valid=1 && out_ready=0.
- Acceptance: a beat is accepted when in_valid & in_ready.
- Tree datapath:
  - Level k has N_IN>>k adders; each output is IN_W+k bits, extended per SIGNED before the add.
  - Each level is a register stage with its own valid bit and in_last tag.
  - The tree result is registered LEVELS cycles after acceptance.
- Accumulate stage (one register stage):
  - On each valid tree result: acc = (first ? 0 : acc) + ext(tree), with ext to OUT_W per SIGNED. Counter increments.
  - A group closes when counter+1 == len_latched, or the tagged in_last is set, or len_latched <= 1.
  - On close: out_data <= acc value including this beat; out_cnt <= beats in the group; out_valid <= 1. Next beat starts a new group.
- Latency: pass-through result appears on out_valid LEVELS+1 cycles after acceptance (5 for the defaults). Throughput is one beat per cycle when not stalled.
- acc_len: sampled with the first accepted beat of a group, carried with the beat, and latched as len_latched. Changes mid-group take effect at the next group.
- Output handshake:
  - out_valid clears on out_ready unless a new group closes in the same cycle.
  - Back-to-back closes with out_ready=1 give consecutive valid cycles.
- Arithmetic: no saturation; the accumulator wraps modulo 2^OUT_W. The tree cannot overflow at TREE_W.
- Reset mid-group: the partial sum and in-flight beats are discarded; nothing is emitted.
- Edge cases:
  - in_last on the first beat of a group gives a 1-beat group regardless of acc_len.
  - acc_len=255 is legal; out_cnt=255.

Test Plan:
- Defaults, acc_len=1, all 16 operands = 1, single beat -> out_valid 5 cycles after acceptance, out_data=16, out_cnt=1.
- SIGNED=1, all operands = 0x8000 -> out_data = -524288 (28-bit 0xFF80000). SIGNED=0, all = 0xFFFF -> out_data=1048560.
- acc_len=4, beats k=1..4, each with all operands = k -> one result out_data=160, out_cnt=4, exactly 8 cycles after the first beat is accepted.
- acc_len=8, in_last on beat 3, operands all 2 each beat -> out_data=96, out_cnt=3; the next 8 beats form a fresh group.
- Back-to-back pass-through stream with out_ready held 0 for 3 cycles once out_valid rises -> in_ready=0 during the hold, out_data stable, no beat lost or duplicated, order preserved.
- reset asserted asynchronously after 2 of 4 beats in a group -> all outputs 0 immediately; the next 4-beat group of all ones gives out_data=64.

Source files
------------

// File: rtl/adder_tree_pipe_acc.sv
// adder_tree_pipe_acc: pipelined N-input adder tree with a group accumulator and valid/ready flow control.
// One register stage per tree level plus an input stage and an accumulate stage; a single stall freezes everything.
module adder_tree_pipe_acc #(
    parameter int N_IN     = 16,
    parameter int IN_W     = 16,
    parameter int SIGNED   = 1,
    parameter int ACC_GROW = 8,
    localparam int LEVELS  = $clog2(N_IN),
    localparam int TREE_W  = IN_W + LEVELS,
    localparam int OUT_W   = TREE_W + ACC_GROW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*IN_W-1:0] in_data,
    input  logic                 in_last,
    input  logic [7:0]           acc_len,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic [7:0]           out_cnt
);
    localparam bit SGN = SIGNED != 0;

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Operands are extended to TREE_W up front; the exact sum never exceeds it, so every level adds at TREE_W.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int W = (N_IN >> k) * TREE_W;
        logic [W-1:0] d, nd;
        logic         v, l, nv, nl;
        logic [7:0]   n, nn;
        if (k == 0) begin : g_in
            always_comb begin
                for (int i = 0; i < N_IN; i++)
                    nd[i*TREE_W +: TREE_W] = {{LEVELS{SGN && in_data[i*IN_W+IN_W-1]}}, in_data[i*IN_W +: IN_W]};
            end
            assign nv = in_valid;
            assign nl = in_last;
            assign nn = acc_len;
        end else begin : g_add
            always_comb begin
                for (int i = 0; i < (N_IN >> k); i++)
                    nd[i*TREE_W +: TREE_W] = g_lvl[k-1].d[2*i*TREE_W +: TREE_W] + g_lvl[k-1].d[(2*i+1)*TREE_W +: TREE_W];
            end
            assign nv = g_lvl[k-1].v;
            assign nl = g_lvl[k-1].l;
            assign nn = g_lvl[k-1].n;
        end
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                d <= '0;
                v <= 1'b0;
                l <= 1'b0;
                n <= '0;
            end else if (!stall) begin
                d <= nd;
                v <= nv;
                l <= nl;
                n <= nn;
            end
        end
    end

    logic [TREE_W-1:0] tree;
    logic [OUT_W-1:0]  acc, sum;
    logic [7:0]        cnt, len_q, len_eff;
    logic              first, close;

    assign tree    = g_lvl[LEVELS].d;
    assign first   = cnt == 8'd0;
    assign len_eff = first ? g_lvl[LEVELS].n : len_q;
    assign sum     = (first ? '0 : acc) + {{ACC_GROW{SGN && tree[TREE_W-1]}}, tree};
    assign close   = g_lvl[LEVELS].v & ((cnt + 8'd1 == len_eff) | g_lvl[LEVELS].l | (len_eff <= 8'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
        end else if (!stall) begin
            out_valid <= close;
            if (g_lvl[LEVELS].v) begin
                acc <= sum;
                cnt <= close ? 8'd0 : cnt + 8'd1;
                if (first) len_q <= g_lvl[LEVELS].n;
            end
            if (close) begin
                out_data <= sum;
                out_cnt  <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_adder_tree_pipe_acc.sv
// tb_adder_tree_pipe_acc: directed stimulus with a group-sum scoreboard, checked by immediate assertions.
module tb_adder_tree_pipe_acc;
    localparam int N = 16;
    localparam int OW = 28;

    logic clk = 0, reset = 1, in_valid = 0, in_last = 0, out_ready = 1;
    logic [N*16-1:0] in_data = '0;
    logic [7:0] acc_len = 8'd1;
    logic in_ready, out_valid, u2_ready, u2_valid;
    logic [OW-1:0] out_data, u2_data, held_data;
    logic [7:0] out_cnt, u2_cnt, held_cnt;

    adder_tree_pipe_acc dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .acc_len(acc_len), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cnt(out_cnt)
    );
    adder_tree_pipe_acc #(.SIGNED(0)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u2_ready), .in_data(in_data),
        .in_last(in_last), .acc_len(acc_len), .out_valid(u2_valid), .out_ready(1'b1),
        .out_data(u2_data), .out_cnt(u2_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0, cyc = 0, acc_cyc = 0, first_cyc = 0, last_out_cyc = 0, n_out = 0, n_mark = 0;
    int m_cnt = 0;
    logic [7:0] m_len = 0;
    logic [OW-1:0] m_sum = 0;
    logic [35:0] q[$];
    logic was_stall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output side of the scoreboard: pop on every transfer, verify holds during backpressure.
    always @(negedge clk) begin
        if (reset) was_stall = 0;
        else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_out", 1, 0);
                else begin
                    logic [35:0] e;
                    e = q.pop_front();
                    check("out_data", 64'(out_data), 64'(e[27:0]));
                    check("out_cnt", 64'(out_cnt), 64'(e[35:28]));
                end
                last_out_cyc = cyc;
                n_out++;
            end else if (out_valid) begin
                check("stall_in_ready", 64'(in_ready), 0);
                if (was_stall) check("stall_stable", {out_cnt, out_data}, {held_cnt, held_data});
                held_data = out_data;
                held_cnt = out_cnt;
            end
            was_stall = out_valid && !out_ready;
        end
    end

    task automatic send(input logic [15:0] val, input logic last, input logic [7:0] len);
        logic ok;
        logic [OW-1:0] bv;
        in_valid = 1;
        in_data = {N{val}};
        in_last = last;
        acc_len = len;
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
        end
        #1 in_valid = 0;
        in_last = 0;
        if (!ok) check("accept_timeout", 0, 1);
        else begin
            acc_cyc = cyc;
            bv = {{12{val[15]}}, val} << 4;
            if (m_cnt == 0) begin
                m_len = len;
                m_sum = 0;
            end
            m_sum += bv;
            if (m_cnt + 1 == m_len || last || m_len <= 1) begin
                q.push_back({8'(m_cnt + 1), m_sum});
                m_cnt = 0;
            end else m_cnt++;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && q.size() > 0; t++) @(posedge clk);
        if (q.size() != 0) check("drain_timeout", 64'(q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 0;
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_data", 64'(out_data), 0);
        check("rst_out_cnt", 64'(out_cnt), 0);

        send(16'd1, 0, 8'd1);
        first_cyc = acc_cyc;
        drain();
        check("lat_pass", 64'(last_out_cyc - first_cyc), 5);

        send(16'h8000, 0, 8'd1);
        drain();

        send(16'hFFFF, 0, 8'd1);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (u2_valid) break;
        end
        check("unsigned_sum", 64'(u2_data), 64'd1048560);
        drain();

        for (int k = 1; k <= 4; k++) begin
            send(16'(k), 0, 8'd4);
            if (k == 1) first_cyc = acc_cyc;
        end
        drain();
        check("lat_group", 64'(last_out_cyc - first_cyc), 8);

        send(16'd2, 0, 8'd8);
        send(16'd2, 0, 8'd8);
        send(16'd2, 1, 8'd8);
        send(16'd1, 0, 8'd8);
        for (int k = 0; k < 7; k++) send(16'd1, 0, 8'd2);
        drain();

        for (int k = 0; k < 255; k++) send(16'd1, 0, 8'd255);
        drain();

        n_mark = n_out;
        fork
            begin
                for (int k = 1; k <= 6; k++) send(16'(k), 0, 8'd1);
            end
            begin
                for (int t = 0; t < 50; t++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) break;
                end
                out_ready = 0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        check("bp_count", 64'(n_out - n_mark), 6);

        out_ready = 0;
        send(16'd3, 0, 8'd1);
        send(16'd1, 0, 8'd4);
        send(16'd1, 0, 8'd4);
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        #2 reset = 1;
        #1;
        check("async_out_valid", 64'(out_valid), 0);
        check("async_out_data", 64'(out_data), 0);
        check("async_out_cnt", 64'(out_cnt), 0);
        check("async_in_ready", 64'(in_ready), 1);
        q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1 reset = 0;
        out_ready = 1;
        for (int k = 0; k < 4; k++) send(16'd1, 0, 8'd4);
        drain();
        check("post_reset_idle", 64'(out_valid), 0);

        check("leftover", 64'(q.size()), 0);
        check("total_outputs", 64'(n_out), 14);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
